// File: rtl/voice_mixer.sv
// Accumulates per-voice subsamples into one mixed sample per period, scales and saturates it,
// and queues finished samples in a small FIFO behind a valid/ready output with sticky status flags.
module voice_mixer #(
    parameter int NUM_VOICES = 16,
    parameter int MIX_SHIFT  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [15:0] i_Subsample,
    input  logic        i_SubsampleReady,
    input  logic        i_SampleReady,
    input  logic        i_ClearFlags,
    output logic [15:0] o_OutSample,
    output logic        o_OutValid,
    input  logic        i_OutReady,
    output logic        o_Clipped,
    output logic        o_Overflow,
    output logic        o_FrameError
);

    localparam int CW = $clog2(NUM_VOICES);
    localparam int AW = 16 + CW;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic [CW-1:0]        cnt;
    logic [15:0]          mixed;
    logic                 clip;

    logic                 pend_valid;
    logic [15:0]          pend_data;

    logic [15:0]          mem [FIFO_DEPTH];
    logic [PW:0]          wr_ptr;
    logic [PW:0]          rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic                 drop;

    logic                 accum;
    logic                 close;
    logic                 frame_err;

    always_comb begin
        accum     = i_SubsampleReady & ~i_SampleReady;
        close     = i_SubsampleReady & i_SampleReady;
        frame_err = (close && cnt != CW'(NUM_VOICES - 1)) || (i_SampleReady && !i_SubsampleReady);

        sum     = acc + $signed({{CW{i_Subsample[15]}}, i_Subsample});
        shifted = sum >>> MIX_SHIFT;
        // In range exactly when every bit from 15 upward matches the sign.
        clip    = !((&shifted[AW-1:15]) || !(|shifted[AW-1:15]));
        if (!clip)
            mixed = shifted[15:0];
        else if (shifted[AW-1])
            mixed = 16'h8000;
        else
            mixed = 16'h7FFF;
    end

    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        pop    = !empty && i_OutReady;
        accept = pend_valid && (!full || pop);
        drop   = pend_valid && full && !pop;

        o_OutValid  = !empty;
        o_OutSample = empty ? '0 : mem[rd_ptr[PW-1:0]];
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            acc        <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (close) begin
                acc <= '0;
                cnt <= '0;
            end else if (accum) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
            pend_valid <= close;
            if (close)
                pend_data <= mixed;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && accept)
            mem[wr_ptr[PW-1:0]] <= pend_data;
    end

    // A set event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Clipped    <= 1'b0;
            o_Overflow   <= 1'b0;
            o_FrameError <= 1'b0;
        end else begin
            o_Clipped    <= (close && clip) || (o_Clipped    && !i_ClearFlags);
            o_Overflow   <= drop            || (o_Overflow   && !i_ClearFlags);
            o_FrameError <= frame_err       || (o_FrameError && !i_ClearFlags);
        end
    end

endmodule
